serial_add_unit: RTL and testbench
==================================

# serial_add_unit

Bit-serial adder stage that drives the team's 1-bit full-adder cell. It accepts two WIDTH-bit operands and a carry-in under a start/done handshake, then feeds one bit pair per clock, LSB first, through a single full-adder instance. It holds the carry in a flip-flop, shifts the sum bits into a result register, and presents the WIDTH-bit sum and carry-out on completion. It sits directly upstream of the full-adder cell and trades area for WIDTH+1 cycles of latency.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an addition; sampled on the rising edge.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- c_in  in  1  carry-in; captured when start is accepted.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; sum/c_out valid from this cycle on.
- sum  out  WIDTH  result A+B+c_in mod 2^WIDTH.
- c_out  out  1  carry out of bit WIDTH-1.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1, load the A/B shift registers, set carry=c_in, bit counter=0, clear the sum shift register, and go to RUN.
- RUN: busy=1. Each edge:
  - Apply A[0], B[0], carry to the full adder.
  - Shift the FA sum bit into the MSB of the sum register.
  - Shift A and B right.
  - Set carry to the FA carry.
  - Increment the counter.
  - When counter = WIDTH-1 on this edge, go to DONE.
- DONE: done=1, busy=0. sum and c_out are final. The next edge goes to IDLE. If start=1 in this cycle, it is accepted exactly as in IDLE and the next state is RUN.
- start in RUN is ignored; operands are not recaptured.
- sum and c_out hold their last value until the next accepted start clears them.
- The counter is $clog2(WIDTH) bits wide. Arithmetic is unsigned; any carry beyond c_out is discarded.
- rst in any state: go to IDLE, zero all registers, and generate no done pulse for the aborted operation.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0; state=IDLE.
- start sampled at edge E0 (in IDLE or DONE):
  - busy=1 for cycles E0+1 .. E0+WIDTH.
  - done=1 in cycle E0+WIDTH+1 only.
- Latency from start to done: WIDTH+1 cycles.
- Maximum throughput: one addition per WIDTH+1 cycles, by asserting start during the done cycle.
- c_out is registered together with the final sum bit; both change on the same edge.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf = signed two's-complement overflow, computed as carry-into-MSB XOR carry-out-of-MSB.
  - ovf is registered on the same edge as c_out and held/cleared like sum.
- SERIAL_ADD_OVF_EN undefined: no ovf port and no extra logic.

## Structure
- Shared package serial_add_pkg:
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH constant.
  - Counter-width function.
- One sub-module, fa_1bit: the combinational full-adder cell with ports c_out, sum, a, b, c_in. It is instantiated once.
- All sequencing logic lives in serial_add_unit.

## Test plan
- Reset: assert rst for 2 cycles with random inputs -> busy=0, done=0, sum=0x00, c_out=0 throughout and after release.
- Basic add (WIDTH=8): a=0x0F, b=0x01, c_in=0, start at E0 -> done only at E0+9, sum=0x10, c_out=0; busy high for exactly 8 cycles.
- Wrap-around: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Also a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
- Handshake:
  - start pulsed at E0+3 with a=0xAA -> ignored; result still from the original operands.
  - start held during the done cycle with a=0x02, b=0x03 -> accepted; next done 9 cycles later with sum=0x05.
- Reset mid-run: rst at E0+4 -> IDLE the next cycle, sum=0, no done pulse at E0+9.
- With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, c_out=1, ovf=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; never below one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_1bit.sv
// rtl/fa_1bit.sv - combinational 1-bit full-adder cell
module fa_1bit (
  output logic c_out,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_unit.sv
// rtl/serial_add_unit.sv - LSB-first bit-serial adder around one fa_1bit cell
// Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.
module serial_add_unit
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_sum;
  logic fa_co;
  logic accept;

  fa_1bit u_fa (
    .c_out (fa_co),
    .sum   (fa_sum),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q)
  );

  // A new start is taken in IDLE and also in DONE for back-to-back operation.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          c_out_d = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final bit.
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      carry_d = c_in;
      cnt_d   = '0;
      sum_d   = '0;
      c_out_d = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_unit.sv
// tb/tb_serial_add_unit.sv - randomized self-checking bench for serial_add_unit
module tb_serial_add_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .c_out (c_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    a    = W'($urandom);
    b    = W'($urandom);
    c_in = 1'($urandom);
  endtask

  // Starts one addition from an IDLE or DONE cycle and ends in its done cycle.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input bit poke);
    int unsigned full;
    int          s_sum;
    logic        exp_ovf;
    full    = int'(ta) + int'(tb) + int'(tc);
    s_sum   = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
    exp_ovf = (s_sum > (2 ** (W - 1)) - 1) || (s_sum < -(2 ** (W - 1)));
    a = ta; b = tb; c_in = tc; start = 1'b1;
    tick();
    start = 1'b0;
    randomize_inputs();
    for (int k = 1; k <= W; k++) begin
      check("busy_run", 32'(busy), 32'(1));
      check("done_run", 32'(done), 32'(0));
      if (poke && k == 3) begin
        start = 1'b1;
        a     = 8'hAA;
      end
      tick();
      start = 1'b0;
    end
    check("done_pulse", 32'(done), 32'(1));
    check("busy_done", 32'(busy), 32'(0));
    check("sum", 32'(sum), full % (2 ** W));
    check("c_out", 32'(c_out), 32'(full >> W));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) check("ovf_model", 32'(exp_ovf), 32'(0));
`endif
  endtask

  task automatic go_idle();
    tick();
    check("done_once", 32'(done), 32'(0));
    check("busy_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    randomize_inputs();

    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom);
      randomize_inputs();
      tick();
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_sum", 32'(sum), 32'(0));
      check("rst_cout", 32'(c_out), 32'(0));
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'(0));
    check("post_rst_done", 32'(done), 32'(0));
    check("post_rst_sum", 32'(sum), 32'(0));
    check("post_rst_cout", 32'(c_out), 32'(0));

    run_add(8'h0F, 8'h01, 1'b0, 1'b0);
    go_idle();
    run_add(8'hFF, 8'h01, 1'b0, 1'b0);
    go_idle();
    run_add(8'hFF, 8'hFF, 1'b1, 1'b0);
    go_idle();
    run_add(8'h31, 8'h42, 1'b1, 1'b1);
    run_add(8'h02, 8'h03, 1'b0, 1'b0);
    go_idle();

    // Reset in the middle of a run must abort without a done pulse.
    a = 8'h5A; b = 8'h33; c_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_sum", 32'(sum), 32'(0));
    check("abort_cout", 32'(c_out), 32'(0));
    for (int k = 5; k <= 10; k++) begin
      tick();
      check("abort_no_done", 32'(done), 32'(0));
    end

    run_add(8'h7F, 8'h01, 1'b0, 1'b0);
    run_add(8'h80, 8'h80, 1'b0, 1'b0);
    go_idle();

    for (int i = 0; i < 40; i++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
